// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the alu_seq sequencer and its benches.
// State codes are 3-bit localparams so legacy decoders can reuse them.
package alu_seq_pkg;

  localparam int DATA_W   = 16;
  localparam int ALU_OP_W = 6;
  localparam int NZ_W     = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOADX = 3'd1;
  localparam logic [2:0] ST_LOADY = 3'd2;
  localparam logic [2:0] ST_EXEC  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 6'h01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_PASSX = 6'h02;

  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
  } req_t;

  // The ALU cards report per-nibble non-zero flags; the whole word is zero
  // only when every nibble reports zero.
  function automatic logic zero_from_nz(input logic [NZ_W-1:0] nz);
    return ~|nz;
  endfunction

endpackage

// File: rtl/alu_seq_optrack.sv
// Operand tracker: remembers the last X and Y words loaded into the ALU
// cards so a request reusing them can skip the bus load cycle.
// Only exists when ALU_SEQ_OPREUSE_EN is defined.
`ifdef ALU_SEQ_OPREUSE_EN
module alu_seq_optrack
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              load_x,
  input  logic              load_y,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] cmp_a,
  input  logic [DATA_W-1:0] cmp_b,
  output logic              x_hit,
  output logic              y_hit
);

  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] y_q;
  logic              x_ok;
  logic              y_ok;

  // Capture whatever word is on the bus when a card load strobe fires.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      x_q  <= '0;
      y_q  <= '0;
      x_ok <= 1'b0;
      y_ok <= 1'b0;
    end else begin
      if (load_x) begin
        x_q  <= load_data;
        x_ok <= 1'b1;
      end
      if (load_y) begin
        y_q  <= load_data;
        y_ok <= 1'b1;
      end
    end
  end

  assign x_hit = x_ok && (x_q == cmp_a);
  assign y_hit = y_ok && (y_q == cmp_b);

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq: sequences one ALU request over a shared bus to external ALU
// cards (load X, load Y, execute) and returns the captured result.
// Optional operand reuse: define ALU_SEQ_OPREUSE_EN to skip reloading an
// X or Y word the cards already hold.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_bar,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_carry,
  output logic                rsp_zero,
  output logic [DATA_W-1:0]   bus_out,
  output logic                bus_oe,
  input  logic [DATA_W-1:0]   bus_in,
  output logic                XI_bar,
  output logic                YI_bar,
  output logic                EO_bar,
  output logic [ALU_OP_W-1:0] ALU_op,
  input  logic                carry_in,
  input  logic [NZ_W-1:0]     nz_in
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  req_t       req_q;
  logic       ready_en;
  logic       req_fire;
  logic       rsp_fire;

  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

`ifdef ALU_SEQ_OPREUSE_EN
  logic x_hit;
  logic y_hit;
  logic skip_y;

  alu_seq_optrack u_optrack (
    .clk       (clk),
    .reset_bar (reset_bar),
    .load_x    (~XI_bar),
    .load_y    (~YI_bar),
    .load_data (bus_out),
    .cmp_a     (req_a),
    .cmp_b     (req_b),
    .x_hit     (x_hit),
    .y_hit     (y_hit)
  );

  // Remember at acceptance whether the Y load can be skipped after LOADX.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      skip_y <= 1'b0;
    end else if (req_fire) begin
      skip_y <= y_hit;
    end
  end
`endif

  // Next-state selection for the load/execute/respond sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req_fire) begin
`ifdef ALU_SEQ_OPREUSE_EN
          if (!x_hit) begin
            state_nxt = ST_LOADX;
          end else if (!y_hit) begin
            state_nxt = ST_LOADY;
          end else begin
            state_nxt = ST_EXEC;
          end
`else
          state_nxt = ST_LOADX;
`endif
        end
      end
      ST_LOADX: begin
`ifdef ALU_SEQ_OPREUSE_EN
        state_nxt = skip_y ? ST_EXEC : ST_LOADY;
`else
        state_nxt = ST_LOADY;
`endif
      end
      ST_LOADY: state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Holds req_ready low until the first clock edge after reset releases.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  // Latch the request fields when it is accepted.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      req_q <= '0;
    end else if (req_fire) begin
      req_q <= '{op: req_op, a: req_a, b: req_b};
    end
  end

  // Sample the ALU card outputs at the end of the execute cycle.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else if (state == ST_EXEC) begin
      rsp_result <= bus_in;
      rsp_carry  <= carry_in;
      rsp_zero   <= zero_from_nz(nz_in);
    end
  end

  // All strobes are decoded from the single state register, so the bus
  // driver and the ALU output enable can never be active together, and
  // async reset to IDLE releases them immediately.
  assign req_ready = ready_en && (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign bus_oe    = (state == ST_LOADX) || (state == ST_LOADY);
  assign bus_out   = (state == ST_LOADX) ? req_q.a :
                     (state == ST_LOADY) ? req_q.b : '0;
  assign XI_bar    = (state != ST_LOADX);
  assign YI_bar    = (state != ST_LOADY);
  assign EO_bar    = (state != ST_EXEC);
  assign ALU_op    = (state == ST_EXEC) ? req_q.op : '0;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the external ALU cards, drives directed and
// random requests, and checks each transaction against a transaction-level
// expectation (ALU arithmetic, expected strobe cycles, operand reuse).
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam logic [5:0] OP_SUB = 6'h03;
  localparam logic [5:0] OP_AND = 6'h04;

  logic        clk;
  logic        reset_bar;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic        rsp_zero;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic [15:0] bus_in;
  logic        XI_bar;
  logic        YI_bar;
  logic        EO_bar;
  logic [5:0]  ALU_op;
  logic        carry_in;
  logic [3:0]  nz_in;

  int total = 0;
  int bad   = 0;

  logic        have_x = 1'b0;
  logic        have_y = 1'b0;
  logic [15:0] last_x = '0;
  logic [15:0] last_y = '0;

  logic [15:0] card_x;
  logic [15:0] card_y;
  logic [16:0] card_out;

  alu_seq dut (
    .clk        (clk),
    .reset_bar  (reset_bar),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .bus_in     (bus_in),
    .XI_bar     (XI_bar),
    .YI_bar     (YI_bar),
    .EO_bar     (EO_bar),
    .ALU_op     (ALU_op),
    .carry_in   (carry_in),
    .nz_in      (nz_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic of the ALU cards: {carry, result}.
  function automatic logic [16:0] alu_ref(input logic [5:0] op, input logic [15:0] x,
                                          input logic [15:0] y);
    case (op)
      ALU_OP_ADD:   return {1'b0, x} + {1'b0, y};
      ALU_OP_PASSX: return {1'b0, x};
      OP_SUB:       return {1'b0, x} + {1'b0, ~y} + 17'd1;
      OP_AND:       return {1'b0, x & y};
      default:      return 17'd0;
    endcase
  endfunction

  // ALU cards latch X/Y from the bus on their load strobes.
  always @(posedge clk) begin
    if (!XI_bar) card_x <= bus_out;
    if (!YI_bar) card_y <= bus_out;
  end

  // Card outputs; outside the execute enable they show junk on purpose.
  always_comb begin
    card_out = alu_ref(ALU_op, card_x, card_y);
    bus_in   = EO_bar ? 16'hA5A5 : card_out[15:0];
    carry_in = EO_bar ? 1'b1 : card_out[16];
    nz_in    = EO_bar ? 4'hF : {|card_out[15:12], |card_out[11:8],
                                |card_out[7:4], |card_out[3:0]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Per-cycle bus and strobe rules.
  always @(negedge clk) begin
    checkOutput("no_contention", 32'(!(bus_oe && !EO_bar)), 32'd1);
    checkOutput("one_strobe",
                32'(({1'b0, ~XI_bar} + {1'b0, ~YI_bar} + {1'b0, ~EO_bar}) <= 2'd1), 32'd1);
    checkOutput("oe_tracks_load", 32'(bus_oe), 32'(!XI_bar || !YI_bar));
    checkOutput("bus_out_quiet", 32'(bus_oe ? 16'h0 : bus_out), 32'd0);
    checkOutput("alu_op_quiet", 32'(EO_bar ? ALU_op : 6'h0), 32'd0);
  end

  // One full request: offer, observe the sequence, hold the response for
  // 'hold' cycles, then consume it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [5:0] op, input int hold);
    logic [16:0] exp;
    logic        skip_x;
    logic        skip_y;
    int          nload;
    int          w;
    int          xc, yc, ec, vc, nx, ny, ne;
    logic [15:0] xbus, ybus;
    logic [5:0]  eop;
    exp = alu_ref(op, a, b);
`ifdef ALU_SEQ_OPREUSE_EN
    skip_x = have_x && (last_x == a);
    skip_y = have_y && (last_y == b);
`else
    skip_x = 1'b0;
    skip_y = 1'b0;
`endif
    nload = (skip_x ? 0 : 1) + (skip_y ? 0 : 1);
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
    if (!req_ready) return;
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_op = op;
    xc = 0; yc = 0; ec = 0; vc = 0; nx = 0; ny = 0; ne = 0;
    xbus = '0; ybus = '0; eop = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!XI_bar) begin nx++; if (xc == 0) begin xc = k; xbus = bus_out; end end
      if (!YI_bar) begin ny++; if (yc == 0) begin yc = k; ybus = bus_out; end end
      if (!EO_bar) begin ne++; if (ec == 0) begin ec = k; eop = ALU_op; end end
      if (rsp_valid) begin
        vc = k;
        break;
      end
      req_valid = 1'(($urandom % 2));
      req_a = 16'($urandom);
      req_b = 16'($urandom);
      req_op = 6'($urandom);
    end
    checkOutput("xi_count", 32'(nx), 32'(skip_x ? 0 : 1));
    checkOutput("yi_count", 32'(ny), 32'(skip_y ? 0 : 1));
    checkOutput("eo_count", 32'(ne), 32'd1);
    if (!skip_x) begin
      checkOutput("xi_cycle", 32'(xc), 32'd1);
      checkOutput("xi_bus", 32'(xbus), 32'(a));
    end
    if (!skip_y) begin
      checkOutput("yi_cycle", 32'(yc), 32'(skip_x ? 1 : 2));
      checkOutput("yi_bus", 32'(ybus), 32'(b));
    end
    checkOutput("eo_cycle", 32'(ec), 32'(nload + 1));
    checkOutput("eo_alu_op", 32'(eop), 32'(op));
    checkOutput("latency", 32'(vc), 32'(nload + 2));
    checkOutput("rsp_result", 32'(rsp_result), 32'(exp[15:0]));
    checkOutput("rsp_carry", 32'(rsp_carry), 32'(exp[16]));
    checkOutput("rsp_zero", 32'(rsp_zero), 32'(exp[15:0] == 16'h0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_result", 32'(rsp_result), 32'(exp[15:0]));
      checkOutput("hold_carry", 32'(rsp_carry), 32'(exp[16]));
      checkOutput("hold_ready_low", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("idle_after_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("idle_after_rsp_ready", 32'(req_ready), 32'd1);
    have_x = 1'b1; last_x = a;
    have_y = 1'b1; last_y = b;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] ra, rb;
    logic [5:0]  ops [4];
    int          seen;
    ops[0] = ALU_OP_ADD; ops[1] = ALU_OP_PASSX; ops[2] = OP_SUB; ops[3] = OP_AND;
    reset_bar = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    #12;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_fields", 32'({rsp_result, rsp_carry, rsp_zero}), 32'd0);
    checkOutput("rst_bus_oe", 32'(bus_oe), 32'd0);
    checkOutput("rst_strobes", 32'({XI_bar, YI_bar, EO_bar}), 32'h7);
    checkOutput("rst_alu_op", 32'(ALU_op), 32'd0);
    repeat (2) @(negedge clk);
    reset_bar = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", 32'(req_ready), 32'd1);

    $display("[TB] single add");
    applyStimulus(16'h00FF, 16'h0001, ALU_OP_ADD, 0);
    $display("[TB] carry and zero");
    applyStimulus(16'hFFFF, 16'h0001, ALU_OP_ADD, 0);
    $display("[TB] backpressure");
    applyStimulus(16'hBEEF, 16'h0F0F, ALU_OP_PASSX, 5);
    applyStimulus(16'h1000, 16'h2000, OP_SUB, 1);

    $display("[TB] reset during execute");
    req_valid = 1'b1; req_a = 16'h4321; req_b = 16'h1111; req_op = ALU_OP_ADD;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("exec_reached", 32'(EO_bar), 32'd0);
    #2 reset_bar = 1'b0;
    #1;
    checkOutput("rst_exec_eo", 32'(EO_bar), 32'd1);
    checkOutput("rst_exec_oe", 32'(bus_oe), 32'd0);
    checkOutput("rst_exec_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_exec_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_exec_result", 32'(rsp_result), 32'd0);
    have_x = 1'b0;
    have_y = 1'b0;
    repeat (3) @(negedge clk);
    reset_bar = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("dropped_no_rsp", 32'(seen), 32'd0);
    checkOutput("ready_after_exec_reset", 32'(req_ready), 32'd1);
    applyStimulus(16'h4321, 16'h1111, ALU_OP_ADD, 0);

    $display("[TB] operand reuse pair");
    applyStimulus(16'h1234, 16'h0001, ALU_OP_ADD, 0);
    applyStimulus(16'h1234, 16'h0002, OP_SUB, 0);

    $display("[TB] random requests");
    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? last_x : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? last_y : 16'($urandom);
      applyStimulus(ra, rb, ops[$urandom_range(0, 3)], $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have: reset_bar  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: req_valid  input  1  request offered; req_ready  output  1  request accepted when both high at a clock edge.
REQ-004 SHALL have: req_op  input  6  ALU operation; req_a  input  16  X operand; req_b  input  16  Y operand.
REQ-005 SHALL have: rsp_valid  output  1  result available; rsp_ready  input  1  result consumed when both high at a clock edge.
REQ-006 SHALL have: rsp_result  output  16  captured ALU value; rsp_carry  output  1  captured carry; rsp_zero  output  1  result-is-zero flag.
REQ-007 SHALL have: bus_out  output  16  data driven to bus; bus_oe  output  1  bus drive enable, active high; bus_in  input  16  bus sample.
REQ-008 SHALL have: XI_bar, YI_bar, EO_bar  output  1 each  active-low X load, Y load and ALU output enable to the ALU cards; ALU_op  output  6  operation to the ALU cards.
REQ-009 SHALL have: carry_in  input  1  carry out of the high ALU card; nz_in  input  4  per-nibble non-zero flags, low card nibbles [1:0], high card nibbles [3:2].

Function
REQ-010 SHALL implement the states IDLE, LOADX, LOADY, EXEC and RESP.
REQ-011 IDLE SHALL: req_ready=1; on handshake, register op/a/b and go to LOADX; otherwise stay.
REQ-012 LOADX SHALL: bus_oe=1, bus_out=a, XI_bar=0 for exactly one cycle, then go to LOADY.
REQ-013 LOADY SHALL: bus_oe=1, bus_out=b, YI_bar=0 for exactly one cycle, then go to EXEC.
REQ-014 EXEC SHALL: bus_oe=0, EO_bar=0, ALU_op=op for one cycle.
REQ-015 At the end of EXEC the block SHALL register rsp_result=bus_in, rsp_carry=carry_in and rsp_zero=~|nz_in, then go to RESP.
REQ-016 RESP SHALL: rsp_valid=1 and result fields held stable until the rsp_ready handshake, then go to IDLE; req_ready=0 in RESP.
REQ-017 Latency SHALL be 4 cycles from the request handshake edge to rsp_valid high (macro disabled).
REQ-018 Outside their states: XI_bar, YI_bar and EO_bar SHALL be 1; ALU_op and bus_out SHALL be 0; bus_oe SHALL be 0.
REQ-019 bus_oe=1 and EO_bar=0 SHALL never coexist in any cycle, including during reset entry.
REQ-020 Only one of XI_bar, YI_bar and EO_bar SHALL be low in any cycle.
REQ-021 req_valid changes outside IDLE SHALL be ignored.
REQ-022 Back-to-back requests SHALL incur one IDLE cycle between RESP and the next LOADX.

Reset
REQ-023 While reset_bar=0 the block SHALL asynchronously force: state=IDLE, req_ready=0, rsp_valid=0, rsp_result/rsp_carry/rsp_zero=0, bus_oe=0, XI_bar=YI_bar=EO_bar=1, ALU_op=0.
REQ-024 An in-flight request at reset SHALL be dropped without a response.
REQ-025 req_ready SHALL first assert in the first cycle after reset_bar deasserts.

Configuration
REQ-026 Macro ALU_SEQ_OPREUSE_EN defined: the block SHALL track the last loaded X and Y values with valid bits, which are cleared by reset.
REQ-027 With ALU_SEQ_OPREUSE_EN defined, LOADX SHALL be skipped when the X valid bit is set and req_a equals the tracked X; LOADY SHALL be skipped likewise for Y; IDLE then goes directly to the next needed state.
REQ-028 Macro undefined: no tracking logic; every request SHALL pass through LOADX and LOADY.

Structure
REQ-029 Shared package alu_seq_pkg SHALL hold the state encoding constants (3-bit), the ALU_OP width, and the ALU_OP_ADD and ALU_OP_PASSX constants used by benches.
REQ-030 The operand tracker SHALL be a sub-module alu_seq_optrack, instantiated only under ALU_SEQ_OPREUSE_EN; the FSM and datapath SHALL live in alu_seq.

Verification
REQ-031 Single add: a=16'h00FF, b=16'h0001, op=ADD, bench ALU model -> XI_bar low cycle 1 with bus_out=00FF; YI_bar low cycle 2 with bus_out=0001; EO_bar low cycle 3; rsp_valid at cycle 4 with result 16'h0100, carry 0, zero 0.
REQ-032 Carry and zero: a=16'hFFFF, b=16'h0001 -> result 16'h0000, rsp_carry=1, rsp_zero=1.
REQ-033 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and result held stable; req_ready=0 throughout; IDLE reached one cycle after rsp_ready=1.
REQ-034 Reset in EXEC: reset_bar pulsed low -> EO_bar=1 and bus_oe=0 immediately; rsp_valid never asserts; next request completes normally.
REQ-035 Contention assertion over 1000 random requests with random rsp_ready -> no cycle with bus_oe=1 and EO_bar=0; at most one strobe low per cycle.
REQ-036 ALU_SEQ_OPREUSE_EN defined: two requests with identical a=16'h1234 and different b -> the second request has no XI_bar pulse and latency 3.
